// File: rtl/spi_master.sv
// SPI mode-0 master sending a 10-bit command/address frame MSB first.
// Read frames (command 2'b11) add a turnaround period and capture one byte from MISO.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       i_spi_master_clk,
  input  logic       i_spi_master_rst,
  input  logic [9:0] i_spi_master_tx_data,
  input  logic       i_spi_master_tx_valid,
  output logic       o_spi_master_ready,
  input  logic       i_spi_master_miso,
  output logic       o_spi_master_sclk,
  output logic       o_spi_master_ss_n,
  output logic       o_spi_master_mosi,
  output logic [7:0] o_spi_master_rx_data,
  output logic       o_spi_master_rx_valid
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] TX    = 3'd2;
  localparam logic [2:0] TURN  = 3'd3;
  localparam logic [2:0] RX    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] divCnt_q, divCnt_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [8:0] txShift_q, txShift_d;
  logic       isRead_q, isRead_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;
  logic       halfEnd;

  assign halfEnd = (divCnt_q == DIV_LAST);

  // sclk_q doubles as the half-period phase: 1 = high half, 0 = low half of a bit.
  always_comb begin
    state_d   = state_q;
    divCnt_d  = divCnt_q;
    bitCnt_d  = bitCnt_q;
    txShift_d = txShift_q;
    isRead_d  = isRead_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_spi_master_tx_valid) begin
          state_d   = SETUP;
          txShift_d = i_spi_master_tx_data[8:0];
          isRead_d  = (i_spi_master_tx_data[9:8] == 2'b11);
          mosi_d    = i_spi_master_tx_data[9];
          divCnt_d  = 8'd0;
          bitCnt_d  = 4'd0;
          sclk_d    = 1'b0;
        end
      end

      SETUP: begin
        if (halfEnd) begin
          state_d  = TX;
          divCnt_d = 8'd0;
          sclk_d   = 1'b1;
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      // The next MOSI bit is launched on the falling edge; zeros shift in behind bit 0.
      TX: begin
        if (!halfEnd) begin
          divCnt_d = divCnt_q + 8'd1;
        end else begin
          divCnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d    = 1'b0;
            mosi_d    = txShift_q[8];
            txShift_d = {txShift_q[7:0], 1'b0};
          end else if (bitCnt_q == 4'd9) begin
            bitCnt_d = 4'd0;
            state_d  = isRead_q ? TURN : DONE;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            sclk_d   = 1'b1;
          end
        end
      end

      TURN: begin
        if (!halfEnd) begin
          divCnt_d = divCnt_q + 8'd1;
        end else begin
          divCnt_d = 8'd0;
          if (bitCnt_q == 4'd1) begin
            bitCnt_d  = 4'd0;
            state_d   = RX;
            sclk_d    = 1'b1;
            rxShift_d = {rxShift_q[6:0], i_spi_master_miso};
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end

      // MISO is captured on the same clock edge that raises SCLK.
      RX: begin
        if (!halfEnd) begin
          divCnt_d = divCnt_q + 8'd1;
        end else begin
          divCnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bitCnt_q == 4'd7) begin
            bitCnt_d  = 4'd0;
            state_d   = DONE;
            rxData_d  = rxShift_q;
            rxValid_d = 1'b1;
          end else begin
            bitCnt_d  = bitCnt_q + 4'd1;
            sclk_d    = 1'b1;
            rxShift_d = {rxShift_q[6:0], i_spi_master_miso};
          end
        end
      end

      DONE: begin
        mosi_d = 1'b0;
        if (halfEnd) begin
          state_d  = IDLE;
          divCnt_d = 8'd0;
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        divCnt_d = 8'd0;
        bitCnt_d = 4'd0;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_spi_master_clk or posedge i_spi_master_rst) begin
    if (i_spi_master_rst) begin
      state_q   <= IDLE;
      divCnt_q  <= 8'd0;
      bitCnt_q  <= 4'd0;
      txShift_q <= 9'd0;
      isRead_q  <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      rxShift_q <= 8'd0;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      divCnt_q  <= divCnt_d;
      bitCnt_q  <= bitCnt_d;
      txShift_q <= txShift_d;
      isRead_q  <= isRead_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
    end
  end

  assign o_spi_master_ready    = (state_q == IDLE);
  assign o_spi_master_ss_n     = (state_q == IDLE) || (state_q == DONE);
  assign o_spi_master_sclk     = sclk_q;
  assign o_spi_master_mosi     = mosi_q;
  assign o_spi_master_rx_data  = rxData_q;
  assign o_spi_master_rx_valid = rxValid_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 and CLK_DIV=1 instances, a frame-timeline model,
// a bit-level SPI slave and per-frame literal expectations.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      txValid;
  logic [1:0]      miso;
  logic [1:0]      ready;
  logic [1:0]      sclk;
  logic [1:0]      ssn;
  logic [1:0]      mosi;
  logic [1:0]      rxValid;
  logic [1:0][9:0] txData;
  logic [1:0][7:0] rxData;
  logic [7:0]      slaveByte [2];

  int assertCount = 0;
  int failCount   = 0;

  logic       mBusy  [2];
  int         mT     [2];
  logic [9:0] mFrame [2];
  logic       mRead  [2];
  logic [7:0] mRx    [2];

  int         litRise  [2][6];
  int         litLow   [2][6];
  logic [9:0] litCap   [2][6];
  logic [7:0] litRx    [2][6];
  int         litPulse [2][6];

  spi_master #(.CLK_DIV(2)) dutDiv2 (
    .i_spi_master_clk      (clk),
    .i_spi_master_rst      (rst),
    .i_spi_master_tx_data  (txData[0]),
    .i_spi_master_tx_valid (txValid[0]),
    .o_spi_master_ready    (ready[0]),
    .i_spi_master_miso     (miso[0]),
    .o_spi_master_sclk     (sclk[0]),
    .o_spi_master_ss_n     (ssn[0]),
    .o_spi_master_mosi     (mosi[0]),
    .o_spi_master_rx_data  (rxData[0]),
    .o_spi_master_rx_valid (rxValid[0])
  );

  spi_master #(.CLK_DIV(1)) dutDiv1 (
    .i_spi_master_clk      (clk),
    .i_spi_master_rst      (rst),
    .i_spi_master_tx_data  (txData[1]),
    .i_spi_master_tx_valid (txValid[1]),
    .o_spi_master_ready    (ready[1]),
    .i_spi_master_miso     (miso[1]),
    .o_spi_master_sclk     (sclk[1]),
    .o_spi_master_ss_n     (ssn[1]),
    .o_spi_master_mosi     (mosi[1]),
    .o_spi_master_rx_data  (rxData[1]),
    .o_spi_master_rx_valid (rxValid[1])
  );

  function automatic int divOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int frameLen(input int d, input logic rd);
    return rd ? 40 * d : 22 * d;
  endfunction

  // Expected {ss_n, sclk, mosi, ready} at cycle tt after acceptance.
  function automatic logic [3:0] expOut(input int tt, input int d, input logic [9:0] f, input logic rd);
    int   u;
    int   b;
    int   idx;
    logic hi;
    if (tt < d) return {1'b0, 1'b0, f[9], 1'b0};
    if (tt < 21 * d) begin
      u   = tt - d;
      b   = u / (2 * d);
      hi  = (u % (2 * d)) < d;
      idx = hi ? 9 - b : 8 - b;
      return {1'b0, hi, (idx >= 0) ? f[idx[3:0]] : 1'b0, 1'b0};
    end
    if (!rd) return 4'b1000;
    if (tt < 23 * d) return 4'b0000;
    if (tt < 39 * d) begin
      u  = tt - 23 * d;
      hi = (u % (2 * d)) < d;
      return {1'b0, hi, 2'b00};
    end
    return 4'b1000;
  endfunction

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s inst%0d at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int i, input logic [9:0] f, input logic [7:0] sb);
    slaveByte[i] = sb;
    txData[i]    = f;
    txValid[i]   = 1'b1;
    tick();
    txValid[i]   = 1'b0;
  endtask

  // Frame timeline model: acceptance when idle and requested, then a fixed-length frame.
  initial begin
    for (int i = 0; i < 2; i++) begin
      mBusy[i] = 1'b0; mT[i] = 0; mFrame[i] = '0; mRead[i] = 1'b0; mRx[i] = 8'h00;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          mBusy[i] = 1'b0; mT[i] = 0; mRx[i] = 8'h00;
        end else if (mBusy[i]) begin
          if (mT[i] == frameLen(divOf(i), mRead[i]) - 1) begin
            mBusy[i] = 1'b0;
          end else begin
            mT[i] = mT[i] + 1;
            if (mRead[i] && mT[i] == 39 * divOf(i)) mRx[i] = slaveByte[i];
          end
        end else if (txValid[i]) begin
          mBusy[i]  = 1'b1;
          mT[i]     = 0;
          mFrame[i] = txData[i];
          mRead[i]  = (txData[i][9:8] == 2'b11);
        end
      end
    end
  end

  // Slave, bus observation and the per-cycle compare against the model.
  initial begin
    logic       prevSclk [2];
    logic       prevSsn  [2];
    int         riseCnt  [2];
    int         lowCnt   [2];
    int         gapCnt   [2];
    int         pulseCnt [2];
    int         doneIdx  [2];
    logic [9:0] cap      [2];
    int         d;
    int         k;
    int         j;
    logic [3:0] e;
    logic       rv;
    for (int i = 0; i < 2; i++) begin
      prevSclk[i] = 1'b0; prevSsn[i] = 1'b1; riseCnt[i] = 0; lowCnt[i] = 0;
      gapCnt[i] = 1000; pulseCnt[i] = 0; doneIdx[i] = 0; cap[i] = '0; miso[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        d = divOf(i);
        if (prevSsn[i] && !ssn[i]) begin
          checkOutput("ssGap", i, 32'(gapCnt[i] >= d), 32'd1);
          riseCnt[i] = 0; cap[i] = '0; lowCnt[i] = 0; pulseCnt[i] = 0; gapCnt[i] = 0;
        end
        if (!ssn[i]) lowCnt[i]++; else gapCnt[i]++;
        if (!prevSclk[i] && sclk[i]) begin
          if (riseCnt[i] < 10) cap[i] = {cap[i][8:0], mosi[i]};
          riseCnt[i]++;
        end
        if (prevSclk[i] && !sclk[i] && riseCnt[i] >= 10 && riseCnt[i] < 18) begin
          k       = 17 - riseCnt[i];
          miso[i] = slaveByte[i][k[2:0]];
        end
        if (rxValid[i]) pulseCnt[i]++;
        prevSclk[i] = sclk[i];
        prevSsn[i]  = ssn[i];

        e  = mBusy[i] ? expOut(mT[i], d, mFrame[i], mRead[i]) : 4'b1001;
        rv = mBusy[i] && mRead[i] && (mT[i] == 39 * d);
        checkOutput("ss_n", i, 32'(ssn[i]), 32'(e[3]));
        checkOutput("sclk", i, 32'(sclk[i]), 32'(e[2]));
        checkOutput("mosi", i, 32'(mosi[i]), 32'(e[1]));
        checkOutput("ready", i, 32'(ready[i]), 32'(e[0]));
        checkOutput("rx_valid", i, 32'(rxValid[i]), 32'(rv));
        checkOutput("rx_data", i, 32'(rxData[i]), 32'(mRx[i]));

        if (mBusy[i] && mT[i] == frameLen(d, mRead[i]) - 1 && doneIdx[i] < 6) begin
          j = doneIdx[i];
          checkOutput("sclkRises", i, 32'(riseCnt[i]), 32'(litRise[i][j]));
          checkOutput("ssLowCycles", i, 32'(lowCnt[i]), 32'(litLow[i][j]));
          checkOutput("slaveMosiBits", i, 32'(cap[i]), 32'(litCap[i][j]));
          checkOutput("rxByte", i, 32'(rxData[i]), 32'(litRx[i][j]));
          checkOutput("rxPulses", i, 32'(pulseCnt[i]), 32'(litPulse[i][j]));
          doneIdx[i]++;
        end
      end
    end
  end

  initial begin
    txValid = '0;
    txData  = '0;
    slaveByte[0] = 8'h00;
    slaveByte[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 6; r++) begin
        litRise[i][r] = 0; litLow[i][r] = 0; litCap[i][r] = '0; litRx[i][r] = 8'h00; litPulse[i][r] = 0;
      end
    end
    litRise[0][0] = 10; litLow[0][0] = 42; litCap[0][0] = 10'b0110101101; litRx[0][0] = 8'h00; litPulse[0][0] = 0;
    litRise[0][1] = 18; litLow[0][1] = 78; litCap[0][1] = 10'b1100000011; litRx[0][1] = 8'hCC; litPulse[0][1] = 1;
    litRise[0][2] = 10; litLow[0][2] = 42; litCap[0][2] = 10'b0000000101; litRx[0][2] = 8'hCC; litPulse[0][2] = 0;
    litRise[0][3] = 10; litLow[0][3] = 42; litCap[0][3] = 10'b0111111111; litRx[0][3] = 8'hCC; litPulse[0][3] = 0;
    litRise[0][4] = 18; litLow[0][4] = 78; litCap[0][4] = 10'b1110100101; litRx[0][4] = 8'hA5; litPulse[0][4] = 1;
    litRise[1][0] = 18; litLow[1][0] = 39; litCap[1][0] = 10'b1100001111; litRx[1][0] = 8'h3C; litPulse[1][0] = 1;

    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] CLK_DIV=1 read frame, slave byte 3C");
    applyStimulus(1, 10'b1100001111, 8'h3C);
    repeat (45) tick();

    $display("[TB] write frame with an ignored request mid-frame");
    applyStimulus(0, 10'b0110101101, 8'h00);
    repeat (10) tick();
    txData[0]  = 10'b1111111111;
    txValid[0] = 1'b1;
    tick();
    txValid[0] = 1'b0;
    repeat (40) tick();

    $display("[TB] read frame, slave byte CC");
    applyStimulus(0, 10'b1100000011, 8'hCC);
    repeat (85) tick();

    $display("[TB] back-to-back frames with tx_valid held high");
    txData[0]  = 10'b0000000101;
    txValid[0] = 1'b1;
    tick();
    txData[0]  = 10'b0111111111;
    repeat (45) tick();
    txValid[0] = 1'b0;
    repeat (50) tick();

    $display("[TB] reset during the 5th TX bit of a read frame");
    applyStimulus(0, 10'b1100000011, 8'h5A);
    repeat (19) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] read frame after reset, slave byte A5");
    applyStimulus(0, 10'b1110100101, 8'hA5);
    repeat (85) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
